// File: rtl/branch_resolve_if.sv
// Prediction / resolution / table-update bundle between the branch predictor
// front end and the branch resolve unit.
interface branch_resolve_if #(
   parameter int AW = 3
) ();
   // Prediction issue (predictor -> resolve unit)
   logic          pred_valid;
   logic [AW-1:0] pred_addr;
   logic          pred_taken;
   logic          pred_ready;
   // Branch outcome (execute -> resolve unit)
   logic          res_valid;
   logic          res_taken;
   // Predictor table update and status pulses (resolve unit -> predictor)
   logic          upd_valid;
   logic [AW-1:0] upd_addr;
   logic          upd_taken;
   logic          mispredict;
   logic          flush;
   logic          orphan;

   // Predictor / execute side
   modport master (
      output pred_valid, pred_addr, pred_taken, res_valid, res_taken,
      input  pred_ready, upd_valid, upd_addr, upd_taken, mispredict, flush, orphan
   );

   // Resolve unit side
   modport slave (
      input  pred_valid, pred_addr, pred_taken, res_valid, res_taken,
      output pred_ready, upd_valid, upd_addr, upd_taken, mispredict, flush, orphan
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of outstanding 1-bit predictions, matched
// against resolved outcomes. Drives the predictor table update, counts
// mispredicts per table entry and in total, and flushes wrong-path predictions.
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int AW    = 3,
   parameter int CNT_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   branch_resolve_if.slave        bus,
   input  logic [AW-1:0]          rd_addr,
   output logic [CNT_W-1:0]       miss_cnt,
   output logic [15:0]            miss_total,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int NENT = 2 ** AW;

   // Queue storage
   logic [AW-1:0]    q_addr_q  [DEPTH];
   logic             q_taken_q [DEPTH];

   // Queue control
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;

   // Mispredict statistics
   logic [CNT_W-1:0] miss_cnt_q [NENT];
   logic [CNT_W-1:0] miss_cnt_d [NENT];
   logic [15:0]      miss_total_q, miss_total_d;

   // Registered update / status outputs
   logic             upd_valid_q,  upd_valid_d;
   logic [AW-1:0]    upd_addr_q,   upd_addr_d;
   logic             upd_taken_q,  upd_taken_d;
   logic             mispredict_q, mispredict_d;
   logic             flush_q,      flush_d;
   logic             orphan_q,     orphan_d;

   // Per-cycle events
   logic             pred_ready;
   logic             push;
   logic             pop;
   logic             miss;
   logic [AW-1:0]    head_addr;
   logic             head_taken;

   assign pred_ready = (count_q != CW'(DEPTH));
   assign push       = bus.pred_valid & pred_ready;
   assign pop        = bus.res_valid & (count_q != '0);
   assign head_addr  = q_addr_q[rd_ptr_q];
   assign head_taken = q_taken_q[rd_ptr_q];
   assign miss       = pop & (head_taken != bus.res_taken);

   // Write the incoming prediction at the tail.
   // NOTE: queue payload has no reset; count/pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr_q[wr_ptr_q]  <= bus.pred_addr;
         q_taken_q[wr_ptr_q] <= bus.pred_taken;
      end
   end

   // Next-state for queue pointers, statistics and the registered pulses.
   // NOTE: every _d gets a default first so no path leaves a latch behind.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      miss_cnt_d   = miss_cnt_q;
      miss_total_d = miss_total_q;
      upd_valid_d  = pop;
      upd_addr_d   = upd_addr_q;
      upd_taken_d  = upd_taken_q;
      mispredict_d = miss;
      flush_d      = 1'b0;
      orphan_d     = bus.res_valid & (count_q == '0);

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end

      if (pop) begin
         upd_addr_d  = head_addr;
         upd_taken_d = bus.res_taken;
      end

      if (miss) begin
         // Everything younger than the head (including a same-cycle push) is
         // wrong-path: empty the queue by snapping the read pointer to the tail.
         rd_ptr_d     = wr_ptr_d;
         count_d      = '0;
         flush_d      = (count_q > CW'(1)) | push;
         miss_total_d = miss_total_q + 16'd1;
         if (miss_cnt_q[head_addr] != '1) begin
            miss_cnt_d[head_addr] = miss_cnt_q[head_addr] + CNT_W'(1);
         end
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // State register with synchronous reset.
   // NOTE: non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         miss_cnt_q   <= '{default: '0};
         miss_total_q <= '0;
         upd_valid_q  <= 1'b0;
         upd_addr_q   <= '0;
         upd_taken_q  <= 1'b0;
         mispredict_q <= 1'b0;
         flush_q      <= 1'b0;
         orphan_q     <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         miss_cnt_q   <= miss_cnt_d;
         miss_total_q <= miss_total_d;
         upd_valid_q  <= upd_valid_d;
         upd_addr_q   <= upd_addr_d;
         upd_taken_q  <= upd_taken_d;
         mispredict_q <= mispredict_d;
         flush_q      <= flush_d;
         orphan_q     <= orphan_d;
      end
   end

   assign bus.pred_ready = pred_ready;
   assign bus.upd_valid  = upd_valid_q;
   assign bus.upd_addr   = upd_addr_q;
   assign bus.upd_taken  = upd_taken_q;
   assign bus.mispredict = mispredict_q;
   assign bus.flush      = flush_q;
   assign bus.orphan     = orphan_q;
   assign miss_cnt       = miss_cnt_q[rd_addr];
   assign miss_total     = miss_total_q;
   assign count          = count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;
   localparam int AW    = 3;
   localparam int CNT_W = 4;

   logic                   clk;
   logic                   reset;
   logic [AW-1:0]          rd_addr;
   logic [CNT_W-1:0]       miss_cnt;
   logic [15:0]            miss_total;
   logic [$clog2(DEPTH):0] count;

   int n_checks = 0;
   int n_fail   = 0;

   branch_resolve_if #(.AW(AW)) bus ();

   branch_resolve_unit #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .rd_addr    (rd_addr),
      .miss_cnt   (miss_cnt),
      .miss_total (miss_total),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, then return 1 time unit after the edge.
   task automatic cyc(input logic pv, input logic [AW-1:0] pa, input logic pt,
                      input logic rv, input logic rt);
      bus.pred_valid = pv;
      bus.pred_addr  = pa;
      bus.pred_taken = pt;
      bus.res_valid  = rv;
      bus.res_taken  = rt;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic t);
      cyc(1'b1, a, t, 1'b0, 1'b0);
   endtask

   task automatic resolve(input logic t);
      cyc(1'b0, '0, 1'b0, 1'b1, t);
   endtask

   task automatic idle();
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expect_upd(input string tag, input logic [AW-1:0] a, input logic t,
                             input logic mp);
      check({tag, " upd_valid"},  bus.upd_valid,  1'b1);
      check({tag, " upd_addr"},   bus.upd_addr,   a);
      check({tag, " upd_taken"},  bus.upd_taken,  t);
      check({tag, " mispredict"}, bus.mispredict, mp);
   endtask

   task automatic sel(input logic [AW-1:0] a);
      rd_addr = a;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      rd_addr = '0;
      bus.pred_valid = 1'b0;
      bus.pred_addr  = '0;
      bus.pred_taken = 1'b0;
      bus.res_valid  = 1'b0;
      bus.res_taken  = 1'b0;
      idle();
      idle();
      reset = 1'b0;

      // Reset state
      check("rst count",      count,          0);
      check("rst pred_ready", bus.pred_ready, 1);
      check("rst upd_valid",  bus.upd_valid,  0);
      check("rst mispredict", bus.mispredict, 0);
      check("rst flush",      bus.flush,      0);
      check("rst orphan",     bus.orphan,     0);
      check("rst miss_total", miss_total,     0);
      sel(3'd1);
      check("rst miss_cnt1",  miss_cnt,       0);

      // 1: three correct predictions
      push(3'd1, 1'b1);
      push(3'd2, 1'b0);
      push(3'd5, 1'b1);
      check("t1 count3", count, 3);
      resolve(1'b1);
      expect_upd("t1 r0", 3'd1, 1'b1, 1'b0);
      check("t1 count2", count, 2);
      resolve(1'b0);
      expect_upd("t1 r1", 3'd2, 1'b0, 1'b0);
      resolve(1'b1);
      expect_upd("t1 r2", 3'd5, 1'b1, 1'b0);
      check("t1 count0",     count,      0);
      check("t1 miss_total", miss_total, 0);
      check("t1 flush",      bus.flush,  0);
      idle();
      check("t1 upd idle",   bus.upd_valid, 0);

      // 2: mispredict with one younger entry -> flush
      push(3'd2, 1'b0);
      push(3'd3, 1'b1);
      resolve(1'b1);
      expect_upd("t2", 3'd2, 1'b1, 1'b1);
      check("t2 flush",      bus.flush,  1);
      check("t2 count",      count,      0);
      check("t2 miss_total", miss_total, 1);
      sel(3'd2);
      check("t2 miss_cnt2",  miss_cnt,   1);
      idle();
      check("t2 mp pulse",    bus.mispredict, 0);
      check("t2 flush pulse", bus.flush,      0);
      check("t2 no stale upd", bus.upd_valid, 0);

      // 3: fill, overfill, wrap-around ordering (pointers start at 1 here)
      push(3'd0, 1'b0);
      push(3'd1, 1'b1);
      push(3'd2, 1'b0);
      push(3'd3, 1'b1);
      check("t3 full count", count,          4);
      check("t3 full ready", bus.pred_ready, 0);
      push(3'd7, 1'b1);
      push(3'd7, 1'b1);
      check("t3 drop count", count,          4);
      check("t3 drop ready", bus.pred_ready, 0);
      // Push while full at cycle start is dropped even with a same-cycle pop.
      cyc(1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
      expect_upd("t3 p0", 3'd0, 1'b0, 1'b0);
      check("t3 full+pop count", count, 3);
      cyc(1'b1, 3'd5, 1'b1, 1'b1, 1'b1);
      expect_upd("t3 p1", 3'd1, 1'b1, 1'b0);
      check("t3 push+pop count", count, 3);
      push(3'd6, 1'b0);
      check("t3 refill count", count, 4);
      resolve(1'b0);
      expect_upd("t3 p2", 3'd2, 1'b0, 1'b0);
      resolve(1'b1);
      expect_upd("t3 p3", 3'd3, 1'b1, 1'b0);
      resolve(1'b1);
      expect_upd("t3 p4", 3'd5, 1'b1, 1'b0);
      resolve(1'b0);
      expect_upd("t3 p5", 3'd6, 1'b0, 1'b0);
      check("t3 count0",     count,      0);
      check("t3 miss_total", miss_total, 1);

      // 4: 20 single-entry mispredicts on addr 6 (no younger entries -> no flush)
      for (int i = 0; i < 20; i++) begin
         push(3'd6, 1'b0);
         resolve(1'b1);
         if (i == 0) begin
            expect_upd("t4 first", 3'd6, 1'b1, 1'b1);
            check("t4 no flush", bus.flush, 0);
         end
      end
      sel(3'd6);
      check("t4 miss_cnt6 sat", miss_cnt,   15);
      check("t4 miss_total",    miss_total, 21);   // 1 from test 2 + 20
      sel(3'd2);
      check("t4 miss_cnt2",     miss_cnt,   1);

      // 5: orphan resolve with simultaneous push
      cyc(1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
      check("t5 orphan",    bus.orphan,    1);
      check("t5 upd_valid", bus.upd_valid, 0);
      check("t5 count",     count,         1);
      idle();
      check("t5 orphan pulse", bus.orphan, 0);
      resolve(1'b1);
      expect_upd("t5 late", 3'd3, 1'b1, 1'b0);
      check("t5 count0", count, 0);

      // 6: reset with 3 queued entries and a pending mispredicting resolve
      push(3'd1, 1'b1);
      push(3'd2, 1'b1);
      push(3'd4, 1'b0);
      check("t6 count3", count, 3);
      reset = 1'b1;
      resolve(1'b0);
      reset = 1'b0;
      check("t6 count",      count,          0);
      check("t6 ready",      bus.pred_ready, 1);
      check("t6 upd_valid",  bus.upd_valid,  0);
      check("t6 mispredict", bus.mispredict, 0);
      check("t6 flush",      bus.flush,      0);
      check("t6 miss_total", miss_total,     0);
      sel(3'd6);
      check("t6 miss_cnt6",  miss_cnt,       0);
      idle();
      check("t6 post upd",   bus.upd_valid,  0);
      check("t6 post flush", bus.flush,      0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety net against a stuck simulation.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
